// File: rtl/apmu_ibex_pkg.sv
// Shared types for the core/PMU performance-counter interface:
// op encoding, register-select decode and flag bit positions.
package apmu_ibex_pkg;

    typedef enum logic [1:0] {
        PMC_IDLE = 2'd0,
        PMC_REQ  = 2'd1,
        PMC_WFP  = 2'd2,
        PMC_WFO  = 2'd3
    } pmc_op_e;

    typedef enum logic [1:0] {
        REG_COUNT   = 2'd0,
        REG_PERIOD  = 2'd1,
        REG_FLAGS   = 2'd2,
        REG_INVALID = 2'd3
    } pmc_reg_sel_e;

    localparam int unsigned PMC_FLAG_OVF_BIT    = 0;
    localparam int unsigned PMC_FLAG_PMATCH_BIT = 1;
    localparam int unsigned PMC_FLAG_W          = 2;

endpackage

// File: rtl/apmu_pmc_counter_slice.sv
// One event counter with its period and sticky pmatch/ovf flags.
// Count writes beat same-cycle events; flag sets beat same-cycle clears.
module apmu_pmc_counter_slice
    import apmu_ibex_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_event,
    input  logic                  i_count_we,
    input  logic                  i_period_we,
    input  logic [CNT_W-1:0]      i_wdata,
    input  logic [PMC_FLAG_W-1:0] i_flag_clr,
    output logic [CNT_W-1:0]      o_count,
    output logic [CNT_W-1:0]      o_period,
    output logic [PMC_FLAG_W-1:0] o_flags
);

    logic [CNT_W-1:0]      r_count;
    logic [CNT_W-1:0]      r_period;
    logic [PMC_FLAG_W-1:0] r_flags;

    logic [CNT_W-1:0]      w_count_inc;
    logic                  w_pmatch_hit;
    logic                  w_ovf_hit;
    logic                  w_inc;
    logic [PMC_FLAG_W-1:0] w_flag_set;

    always_comb begin
        w_count_inc  = r_count + CNT_W'(1);
        w_pmatch_hit = (r_period != '0) && (w_count_inc == r_period);
        w_ovf_hit    = &r_count;
        w_inc        = i_event && !i_count_we;
        w_flag_set   = '0;
        if (w_inc) begin
            if (w_pmatch_hit) begin
                w_flag_set[PMC_FLAG_PMATCH_BIT] = 1'b1;
            end else if (w_ovf_hit) begin
                w_flag_set[PMC_FLAG_OVF_BIT] = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count  <= '0;
            r_period <= '0;
            r_flags  <= '0;
        end else begin
            if (i_count_we) begin
                r_count <= i_wdata;
            end else if (w_inc) begin
                r_count <= (w_pmatch_hit || w_ovf_hit) ? '0 : w_count_inc;
            end
            if (i_period_we) begin
                r_period <= i_wdata;
            end
            r_flags <= (r_flags & ~i_flag_clr) | w_flag_set;
        end
    end

    assign o_count  = r_count;
    assign o_period = r_period;
    assign o_flags  = r_flags;

endmodule

// File: rtl/apmu_pmc_responder.sv
// PMU-side responder: counter bank with register access and blocking WFP/WFO waits.
// Optional APMU_PMC_WAIT_TIMEOUT_EN bounds waits to TIMEOUT_CYCLES with an error response.
module apmu_pmc_responder
    import apmu_ibex_pkg::*;
#(
    parameter int unsigned NUM_COUNTERS   = 8,
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  pmc_op_e                 counter_op_i,
    output logic                    counter_gnt_o,
    output logic                    counter_rvalid_o,
    output logic                    counter_err_o,
    input  logic [31:0]             counter_addr_i,
    input  logic                    counter_we_i,
    input  logic [31:0]             counter_wdata_i,
    output logic [31:0]             counter_rdata_o,
    input  logic [NUM_COUNTERS-1:0] event_i
);

    localparam int unsigned IW     = $clog2(NUM_COUNTERS);
    localparam int unsigned HI_LSB = IW + 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RESP,
        S_WAIT
    } state_e;

    state_e      r_state;
    pmc_op_e     r_op;
    logic [IW-1:0] r_idx;
    logic        r_rvalid;
    logic        r_err;
    logic [31:0] r_rdata;

`ifdef APMU_PMC_WAIT_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_wait_cnt;
`endif

    logic [CNT_W-1:0]      w_count  [NUM_COUNTERS];
    logic [CNT_W-1:0]      w_period [NUM_COUNTERS];
    logic [PMC_FLAG_W-1:0] w_flags  [NUM_COUNTERS];
    logic [PMC_FLAG_W-1:0] w_flag_clr [NUM_COUNTERS];
    logic [NUM_COUNTERS-1:0] w_count_we;
    logic [NUM_COUNTERS-1:0] w_period_we;

    logic [IW-1:0]         w_idx;
    pmc_reg_sel_e          w_sel;
    logic                  w_hi_bad;
    logic                  w_req_ok;
    logic                  w_accept;
    logic                  w_wr_ok;
    logic [31:0]           w_rd_data;
    logic [31:0]           w_wait_data;
    logic                  w_tflag;
    logic                  w_fire;
    logic [PMC_FLAG_W-1:0] w_consume_mask;
    logic                  w_unused_addr;

    assign w_idx         = counter_addr_i[2 +: IW];
    assign w_sel         = pmc_reg_sel_e'(counter_addr_i[2+IW +: 2]);
    assign w_hi_bad      = |counter_addr_i[31:HI_LSB];
    assign w_req_ok      = !w_hi_bad && (w_sel != REG_INVALID);
    assign w_accept      = (r_state == S_IDLE) && (counter_op_i != PMC_IDLE);
    assign w_wr_ok       = w_accept && (counter_op_i == PMC_REQ) && counter_we_i && w_req_ok;
    assign w_unused_addr = ^counter_addr_i[1:0];

    // A wait fires on the target flag of the latched counter; the fire also consumes it.
    always_comb begin
        w_tflag = (r_op == PMC_WFP) ? w_flags[r_idx][PMC_FLAG_PMATCH_BIT]
                                    : w_flags[r_idx][PMC_FLAG_OVF_BIT];
        w_fire  = (r_state == S_WAIT) && w_tflag;
        w_consume_mask = '0;
        if (w_fire) begin
            if (r_op == PMC_WFP) begin
                w_consume_mask[PMC_FLAG_PMATCH_BIT] = 1'b1;
            end else begin
                w_consume_mask[PMC_FLAG_OVF_BIT] = 1'b1;
            end
        end
    end

    always_comb begin
        w_count_we  = '0;
        w_period_we = '0;
        for (int unsigned k = 0; k < NUM_COUNTERS; k++) begin
            w_flag_clr[k] = '0;
            if (w_wr_ok && (w_idx == IW'(k))) begin
                w_count_we[k]  = (w_sel == REG_COUNT);
                w_period_we[k] = (w_sel == REG_PERIOD);
                if (w_sel == REG_FLAGS) begin
                    w_flag_clr[k] = counter_wdata_i[PMC_FLAG_W-1:0];
                end
            end
            if (r_idx == IW'(k)) begin
                w_flag_clr[k] = w_flag_clr[k] | w_consume_mask;
            end
        end
    end

    always_comb begin
        w_rd_data = '0;
        unique case (w_sel)
            REG_COUNT:  w_rd_data[CNT_W-1:0]      = w_count[w_idx];
            REG_PERIOD: w_rd_data[CNT_W-1:0]      = w_period[w_idx];
            REG_FLAGS:  w_rd_data[PMC_FLAG_W-1:0] = w_flags[w_idx];
            default:    w_rd_data                 = '0;
        endcase
        w_wait_data = '0;
        w_wait_data[CNT_W-1:0] = w_count[r_idx];
    end

    for (genvar k = 0; k < NUM_COUNTERS; k++) begin : g_slice
        apmu_pmc_counter_slice #(
            .CNT_W (CNT_W)
        ) u_slice (
            .i_clk       (clk_i),
            .i_rst       (rst_i),
            .i_event     (event_i[k]),
            .i_count_we  (w_count_we[k]),
            .i_period_we (w_period_we[k]),
            .i_wdata     (counter_wdata_i[CNT_W-1:0]),
            .i_flag_clr  (w_flag_clr[k]),
            .o_count     (w_count[k]),
            .o_period    (w_period[k]),
            .o_flags     (w_flags[k])
        );
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_op     <= PMC_IDLE;
            r_idx    <= '0;
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
`ifdef APMU_PMC_WAIT_TIMEOUT_EN
            r_wait_cnt <= '0;
`endif
        end else begin
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (counter_op_i == PMC_REQ) begin
                            r_state  <= S_RESP;
                            r_rvalid <= 1'b1;
                            if (!w_req_ok) begin
                                r_err <= 1'b1;
                            end else if (!counter_we_i) begin
                                r_rdata <= w_rd_data;
                            end
                        end else if (w_hi_bad) begin
                            r_state  <= S_RESP;
                            r_rvalid <= 1'b1;
                            r_err    <= 1'b1;
                        end else begin
                            r_state <= S_WAIT;
                            r_op    <= counter_op_i;
                            r_idx   <= w_idx;
`ifdef APMU_PMC_WAIT_TIMEOUT_EN
                            r_wait_cnt <= '0;
`endif
                        end
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                S_WAIT: begin
                    if (w_fire) begin
                        r_state  <= S_RESP;
                        r_rvalid <= 1'b1;
                        r_rdata  <= w_wait_data;
                    end else if (counter_op_i == PMC_IDLE) begin
                        r_state <= S_IDLE;
                    end
`ifdef APMU_PMC_WAIT_TIMEOUT_EN
                    else if (r_wait_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        r_state  <= S_RESP;
                        r_rvalid <= 1'b1;
                        r_err    <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + TW'(1);
                    end
`endif
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign counter_gnt_o    = (r_state == S_IDLE);
    assign counter_rvalid_o = r_rvalid;
    assign counter_err_o    = r_err;
    assign counter_rdata_o  = r_rdata;

endmodule

// File: tb/tb_apmu_pmc_responder.sv
// Directed self-checking bench for apmu_pmc_responder (8 counters, 32-bit).
// Build with +define+APMU_PMC_WAIT_TIMEOUT_EN to exercise the wait timeout.
module tb_apmu_pmc_responder;
    import apmu_ibex_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    pmc_op_e     op  = PMC_IDLE;
    logic        gnt;
    logic        rvalid;
    logic        err;
    logic [31:0] addr  = '0;
    logic        we    = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic [7:0]  ev    = '0;

    int checks = 0;
    int errors = 0;

    logic        rv, er, gn;
    logic [31:0] rd;

    apmu_pmc_responder #(
        .NUM_COUNTERS   (8),
        .CNT_W          (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .counter_op_i     (op),
        .counter_gnt_o    (gnt),
        .counter_rvalid_o (rvalid),
        .counter_err_o    (err),
        .counter_addr_i   (addr),
        .counter_we_i     (we),
        .counter_wdata_i  (wdata),
        .counter_rdata_o  (rdata),
        .event_i          (ev)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    function automatic logic [31:0] ra(input int unsigned sel, input int unsigned idx);
        return 32'((sel << 5) | (idx << 2));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One REQ transaction from S_IDLE; returns what is seen in the cycle after accept.
    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [7:0] e, output logic o_rv, output logic [31:0] o_rd,
                          output logic o_er, output logic o_gn);
        op = PMC_REQ; addr = a; we = w; wdata = d; ev = e;
        tick();
        op = PMC_IDLE; we = 1'b0; ev = '0;
        o_rv = rvalid; o_rd = rdata; o_er = err; o_gn = gnt;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (gnt !== 1'b1) begin errors++; $display("FAIL rst_gnt got %0b want 1", gnt); end
        checks++; if ({rvalid, err} !== 2'b00) begin errors++; $display("FAIL rst_rv_err got %b want 00", {rvalid, err}); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h want 0", rdata); end
        rst = 1'b0;
        tick();
        do_req(1'b0, ra(0, 0), 32'h0, 8'h00, rv, rd, er, gn);
        checks++; if ({rv, er, rd} !== {1'b1, 1'b0, 32'h0}) begin errors++; $display("FAIL rst_count0 got rv=%0b err=%0b rd=%h want 1 0 0", rv, er, rd); end
    endtask

    task automatic test_write_read();
        do_req(1'b1, ra(0, 3), 32'h10, 8'h00, rv, rd, er, gn);
        checks++; if ({rv, er, gn} !== 3'b100) begin errors++; $display("FAIL wr_resp got rv/err/gnt=%b want 100", {rv, er, gn}); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL wr_rdata got %h want 0", rd); end
        checks++; if ({rvalid, gnt} !== 2'b01) begin errors++; $display("FAIL wr_pulse got rv/gnt=%b want 01", {rvalid, gnt}); end
        ev = 8'h08; tick(); tick(); ev = '0;
        do_req(1'b0, ra(0, 3), 32'h0, 8'h00, rv, rd, er, gn);
        checks++; if ({rv, er, rd} !== {1'b1, 1'b0, 32'h12}) begin errors++; $display("FAIL rd_count3 got rv=%0b err=%0b rd=%h want 1 0 12", rv, er, rd); end
        do_req(1'b0, ra(0, 3), 32'h0, 8'h08, rv, rd, er, gn);
        checks++; if (rd !== 32'h12) begin errors++; $display("FAIL rd_accept_value got %h want 12", rd); end
        do_req(1'b0, ra(0, 3), 32'h0, 8'h00, rv, rd, er, gn);
        checks++; if (rd !== 32'h13) begin errors++; $display("FAIL rd_after_event got %h want 13", rd); end
        do_req(1'b1, ra(1, 5), 32'hABCD, 8'h00, rv, rd, er, gn);
        do_req(1'b0, ra(1, 5), 32'h0, 8'h00, rv, rd, er, gn);
        checks++; if (rd !== 32'hABCD) begin errors++; $display("FAIL rd_period5 got %h want abcd", rd); end
    endtask

    task automatic test_invalid();
        do_req(1'b0, ra(3, 0), 32'h0, 8'h00, rv, rd, er, gn);
        checks++; if ({rv, er, rd} !== {1'b1, 1'b1, 32'h0}) begin errors++; $display("FAIL inv_sel3 got rv=%0b err=%0b rd=%h want 1 1 0", rv, er, rd); end
        do_req(1'b0, 32'h0000_008C, 32'h0, 8'h00, rv, rd, er, gn);
        checks++; if ({rv, er, rd} !== {1'b1, 1'b1, 32'h0}) begin errors++; $display("FAIL inv_hi_rd got rv=%0b err=%0b rd=%h want 1 1 0", rv, er, rd); end
        do_req(1'b1, 32'h8000_000C, 32'h55, 8'h00, rv, rd, er, gn);
        checks++; if ({rv, er, rd} !== {1'b1, 1'b1, 32'h0}) begin errors++; $display("FAIL inv_hi_wr got rv=%0b err=%0b rd=%h want 1 1 0", rv, er, rd); end
        do_req(1'b0, ra(0, 3), 32'h0, 8'h00, rv, rd, er, gn);
        checks++; if (rd !== 32'h13) begin errors++; $display("FAIL inv_no_change got %h want 13", rd); end
    endtask

    task automatic test_period_wait();
        do_req(1'b1, ra(1, 1), 32'h4, 8'h00, rv, rd, er, gn);
        do_req(1'b1, ra(0, 1), 32'h0, 8'h00, rv, rd, er, gn);
        op = PMC_WFP; addr = ra(0, 1);
        tick();
        checks++; if ({gnt, rvalid} !== 2'b00) begin errors++; $display("FAIL wfp_wait got gnt/rv=%b want 00", {gnt, rvalid}); end
        ev = 8'h02;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL wfp_early ev%0d got rv=%0b want 0", i, rvalid); end
        end
        ev = '0;
        tick();
        checks++; if ({rvalid, err, rdata} !== {1'b1, 1'b0, 32'h0}) begin errors++; $display("FAIL wfp_fire got rv=%0b err=%0b rd=%h want 1 0 0", rvalid, err, rdata); end
        op = PMC_IDLE;
        tick();
        do_req(1'b0, ra(2, 1), 32'h0, 8'h00, rv, rd, er, gn);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL wfp_pmatch_clr got %h want 0", rd); end
    endtask

    task automatic test_overflow_wait();
        do_req(1'b1, ra(0, 0), 32'hFFFF_FFFF, 8'h00, rv, rd, er, gn);
        op = PMC_WFO; addr = ra(0, 0);
        tick();
        ev = 8'h01; tick(); ev = '0;
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL wfo_early got rv=%0b want 0", rvalid); end
        tick();
        checks++; if ({rvalid, err, rdata} !== {1'b1, 1'b0, 32'h0}) begin errors++; $display("FAIL wfo_fire got rv=%0b err=%0b rd=%h want 1 0 0", rvalid, err, rdata); end
        op = PMC_IDLE;
        tick();
        do_req(1'b0, ra(2, 0), 32'h0, 8'h00, rv, rd, er, gn);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL wfo_ovf_clr got %h want 0", rd); end
        // flag already set before the wait: two-cycle latency, sel field ignored
        do_req(1'b1, ra(0, 0), 32'hFFFF_FFFF, 8'h00, rv, rd, er, gn);
        ev = 8'h01; tick(); ev = '0;
        do_req(1'b0, ra(2, 0), 32'h0, 8'h00, rv, rd, er, gn);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL wfo_preset_flag got %h want 1", rd); end
        op = PMC_WFO; addr = ra(2, 0);
        tick();
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL wfo_pre_lat1 got rv=%0b want 0", rvalid); end
        tick();
        checks++; if ({rvalid, err, rdata} !== {1'b1, 1'b0, 32'h0}) begin errors++; $display("FAIL wfo_pre_lat2 got rv=%0b err=%0b rd=%h want 1 0 0", rvalid, err, rdata); end
        op = PMC_IDLE;
        tick();
        do_req(1'b0, ra(2, 0), 32'h0, 8'h00, rv, rd, er, gn);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL wfo_pre_clr got %h want 0", rd); end
        op = PMC_WFO; addr = 32'h0000_0100;
        tick();
        op = PMC_IDLE;
        checks++; if ({rvalid, err, rdata} !== {1'b1, 1'b1, 32'h0}) begin errors++; $display("FAIL wfo_bad_addr got rv=%0b err=%0b rd=%h want 1 1 0", rvalid, err, rdata); end
        tick();
    endtask

    task automatic test_collisions();
        do_req(1'b1, ra(0, 2), 32'h5, 8'h04, rv, rd, er, gn);
        do_req(1'b0, ra(0, 2), 32'h0, 8'h00, rv, rd, er, gn);
        checks++; if (rd !== 32'h5) begin errors++; $display("FAIL col_write_event got %h want 5", rd); end
        do_req(1'b1, ra(0, 6), 32'hFFFF_FFFF, 8'h00, rv, rd, er, gn);
        ev = 8'h40; tick(); ev = '0;
        do_req(1'b1, ra(0, 6), 32'hFFFF_FFFF, 8'h00, rv, rd, er, gn);
        do_req(1'b1, ra(2, 6), 32'h1, 8'h40, rv, rd, er, gn);
        do_req(1'b0, ra(2, 6), 32'h0, 8'h00, rv, rd, er, gn);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL col_w1c_set got %h want 1", rd); end
        do_req(1'b1, ra(2, 6), 32'h3, 8'h00, rv, rd, er, gn);
        do_req(1'b0, ra(2, 6), 32'h0, 8'h00, rv, rd, er, gn);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL col_w1c_plain got %h want 0", rd); end
        // wait consumes ovf while the same counter overflows again
        do_req(1'b1, ra(0, 4), 32'hFFFF_FFFF, 8'h00, rv, rd, er, gn);
        ev = 8'h10; tick(); ev = '0;
        do_req(1'b1, ra(0, 4), 32'hFFFF_FFFF, 8'h00, rv, rd, er, gn);
        op = PMC_WFO; addr = ra(0, 4);
        tick();
        ev = 8'h10; tick(); ev = '0;
        checks++; if ({rvalid, rdata} !== {1'b1, 32'hFFFF_FFFF}) begin errors++; $display("FAIL col_fire got rv=%0b rd=%h want 1 ffffffff", rvalid, rdata); end
        op = PMC_IDLE;
        tick();
        do_req(1'b0, ra(2, 4), 32'h0, 8'h00, rv, rd, er, gn);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL col_consume_set got %h want 1", rd); end
    endtask

    task automatic test_abort();
        do_req(1'b1, ra(0, 7), 32'hFFFF_FFFF, 8'h00, rv, rd, er, gn);
        ev = 8'h80; tick(); ev = '0;
        op = PMC_WFP; addr = ra(0, 7);
        tick(); tick(); tick();
        checks++; if ({gnt, rvalid} !== 2'b00) begin errors++; $display("FAIL abort_wait got gnt/rv=%b want 00", {gnt, rvalid}); end
        op = PMC_IDLE;
        tick();
        checks++; if ({gnt, rvalid} !== 2'b10) begin errors++; $display("FAIL abort_idle got gnt/rv=%b want 10", {gnt, rvalid}); end
        tick();
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL abort_no_rv got %0b want 0", rvalid); end
        do_req(1'b0, ra(2, 7), 32'h0, 8'h00, rv, rd, er, gn);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL abort_flag got %h want 1", rd); end
    endtask

    task automatic test_unbounded_or_timeout();
        int n;
        op = PMC_WFP; addr = ra(0, 5);
        tick();
        n = 0;
        while (rvalid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
`ifdef APMU_PMC_WAIT_TIMEOUT_EN
        checks++; if ({rvalid, err, rdata} !== {1'b1, 1'b1, 32'h0}) begin errors++; $display("FAIL timeout_resp got rv=%0b err=%0b rd=%h want 1 1 0", rvalid, err, rdata); end
        checks++; if (n !== 16) begin errors++; $display("FAIL timeout_latency got %0d want 16", n); end
        op = PMC_IDLE;
        tick();
`else
        checks++; if ({rvalid, gnt} !== 2'b00) begin errors++; $display("FAIL unbounded_wait got rv/gnt=%b want 00", {rvalid, gnt}); end
        op = PMC_IDLE;
        tick();
        checks++; if (gnt !== 1'b1) begin errors++; $display("FAIL unbounded_abort got gnt=%0b want 1", gnt); end
`endif
    endtask

    task automatic test_reset_midwait();
        op = PMC_WFP; addr = ra(0, 5);
        tick(); tick();
        #2 rst = 1'b1;
        #1;
        checks++; if ({gnt, rvalid, err} !== 3'b100) begin errors++; $display("FAIL rst_mid got gnt/rv/err=%b want 100", {gnt, rvalid, err}); end
        op = PMC_IDLE;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL rst_no_rv c%0d got %0b want 0", i, rvalid); end
        end
        do_req(1'b0, ra(0, 3), 32'h0, 8'h00, rv, rd, er, gn);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_count3 got %h want 0", rd); end
        do_req(1'b0, ra(1, 5), 32'h0, 8'h00, rv, rd, er, gn);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_period5 got %h want 0", rd); end
        do_req(1'b0, ra(2, 7), 32'h0, 8'h00, rv, rd, er, gn);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_flags7 got %h want 0", rd); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_invalid();
        test_period_wait();
        test_overflow_wait();
        test_collisions();
        test_abort();
        test_unbounded_or_timeout();
        test_reset_midwait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
